// File: rtl/alu_chunk_sequencer.sv
// Drives a narrow combinational ALU one chunk per cycle, LS chunk first, chaining
// carry between chunks, and returns the assembled wide result over valid/ready.
module alu_chunk_sequencer #(
  parameter int unsigned N      = 4,
  parameter int unsigned CHUNKS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [N*CHUNKS-1:0] req_a,
  input  logic [N*CHUNKS-1:0] req_b,
  input  logic                req_cin,
  output logic [2:0]          alu_c,
  output logic [N-1:0]        alu_a,
  output logic [N-1:0]        alu_b,
  output logic                alu_cin,
  input  logic [N-1:0]        alu_f,
  input  logic                alu_cout,
  input  logic                alu_v,
  input  logic                alu_z,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [N*CHUNKS-1:0] rsp_f,
  output logic                rsp_cout,
  output logic                rsp_v,
  output logic                rsp_z
);

  localparam int unsigned W  = N * CHUNKS;
  localparam int unsigned CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [2:0]     op_r;
  logic [W-1:0]   a_r, b_r, res_r;
  logic           carry_r, z_acc, cout_r, v_r;
  logic [CW-1:0]  cnt;
  logic           last;

  assign last = (cnt == CW'(CHUNKS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_f     = '0;
    rsp_cout  = 1'b0;
    rsp_v     = 1'b0;
    rsp_z     = 1'b0;
    alu_c     = 3'b000;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = RUN;
      end
      RUN: begin
        alu_c   = op_r;
        alu_a   = a_r[N-1:0];
        alu_b   = b_r[N-1:0];
        alu_cin = carry_r;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_f     = res_r;
        rsp_cout  = cout_r;
        rsp_v     = v_r;
        rsp_z     = z_acc;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, result assembly and flag accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= 3'b000;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      z_acc   <= 1'b0;
      cout_r  <= 1'b0;
      v_r     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_r    <= req_op;
            a_r     <= req_a;
            b_r     <= req_b;
            carry_r <= req_cin;
            cnt     <= '0;
            z_acc   <= 1'b1;
          end
        end
        RUN: begin
          a_r     <= a_r >> N;
          b_r     <= b_r >> N;
          res_r   <= {alu_f, res_r[W-1:N]};
          carry_r <= alu_cout;
          z_acc   <= z_acc & alu_z;
          cnt     <= last ? '0 : cnt + CW'(1);
          // Whole-word C and V come only from the most-significant chunk
          if (last) begin
            cout_r <= alu_cout;
            v_r    <= alu_v;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_chunk_sequencer.sv
// Randomized and directed bench for alu_chunk_sequencer, checked against a
// whole-word add model with an adder-style ALU attached to the chunk port.
module tb_alu_chunk_sequencer;

  localparam int unsigned N      = 4;
  localparam int unsigned CHUNKS = 4;
  localparam int unsigned W      = N * CHUNKS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_cin, rsp_valid, rsp_ready;
  logic [2:0]    req_op, alu_c;
  logic [W-1:0]  req_a, req_b, rsp_f;
  logic [N-1:0]  alu_a, alu_b, alu_f;
  logic          alu_cin, alu_cout, alu_v, alu_z, rsp_cout, rsp_v, rsp_z;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_chunk_sequencer #(.N(N), .CHUNKS(CHUNKS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_c(alu_c), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_v(alu_v), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f),
    .rsp_cout(rsp_cout), .rsp_v(rsp_v), .rsp_z(rsp_z)
  );

  // Chunk ALU: F = A + B + Cin regardless of op
  logic [N:0] chunk_sum;
  always_comb begin
    chunk_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
    alu_f     = chunk_sum[N-1:0];
    alu_cout  = chunk_sum[N];
    alu_v     = (alu_a[N-1] == alu_b[N-1]) && (chunk_sum[N-1] != alu_a[N-1]);
    alu_z     = (chunk_sum[N-1:0] == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_f"},     32'(rsp_f), 32'd0);
    check({tag, " rsp_flags"}, 32'({rsp_cout, rsp_v, rsp_z}), 32'd0);
    check({tag, " alu_out"},   32'({alu_c, alu_a, alu_b, alu_cin}), 32'd0);
  endtask

  // Runs one request. hold: cycles rsp_ready stays low in DONE. abort_at >= 0
  // pulses reset after that many chunks. pend: a request presented during DONE.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int hold, input int abort_at,
                        input logic pend);
    logic [W:0]   full;
    logic [W-1:0] exp_f, mask;
    logic [W:0]   part;
    logic         exp_cout, exp_v, exp_z;
    full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_f    = full[W-1:0];
    exp_cout = full[W];
    exp_v    = (a[W-1] == b[W-1]) && (exp_f[W-1] != a[W-1]);
    exp_z    = (exp_f == '0);

    @(negedge clk);
    check("accept req_ready", 32'(req_ready), 32'd1);
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < CHUNKS; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < CHUNKS + 2; j++) begin
          @(negedge clk);
          check("abort no rsp", 32'(rsp_valid), 32'd0);
        end
        return;
      end
      mask = (k == 0) ? '0 : W'((64'd1 << (N * k)) - 64'd1);
      part = {1'b0, a & mask} + {1'b0, b & mask} + {{W{1'b0}}, cin};
      check("run alu_c",   32'(alu_c), 32'(op));
      check("run alu_a",   32'(alu_a), 32'((a >> (N * k)) & W'(15)));
      check("run alu_b",   32'(alu_b), 32'((b >> (N * k)) & W'(15)));
      check("run alu_cin", 32'(alu_cin), 32'((part >> (N * k)) & (W + 1)'(1)));
      check("run handshake", 32'({req_ready, rsp_valid}), 32'd0);
      @(posedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      if (pend) begin
        req_op = 3'b000; req_a = 16'h0ABC; req_b = 16'h0101; req_cin = 1'b1; req_valid = 1'b1;
      end
      check("done rsp_valid", 32'(rsp_valid), 32'd1);
      check("done req_ready", 32'(req_ready), 32'd0);
      check("done rsp_f",     32'(rsp_f), 32'(exp_f));
      check("done flags",     32'({rsp_cout, rsp_v, rsp_z}), 32'({exp_cout, exp_v, exp_z}));
      check("done alu_c",     32'({alu_c, alu_cin}), 32'd0);
      rsp_ready = (h == hold);
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post rsp_valid", 32'(rsp_valid), 32'd0);
    check("post req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_cin = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    run_op(3'b000, 16'h00FF, 16'h0001, 1'b0, 0, -1, 1'b0);
    run_op(3'b000, 16'hFFFF, 16'h0001, 1'b0, 0, -1, 1'b0);
    run_op(3'b000, 16'h7FFF, 16'h0001, 1'b0, 0, -1, 1'b0);
    run_op(3'b000, 16'h0010, 16'h0000, 1'b0, 0, -1, 1'b0);
    run_op(3'b101, 16'h1357, 16'h2468, 1'b1, 0, -1, 1'b0);
    run_op(3'b010, 16'h8000, 16'h8000, 1'b0, 5, -1, 1'b1);
    run_op(3'b000, 16'h0ABC, 16'h0101, 1'b1, 0, -1, 1'b0);
    run_op(3'b011, 16'hDEAD, 16'hBEEF, 1'b0, 0, 2, 1'b0);
    run_op(3'b000, 16'h1234, 16'h1111, 1'b0, 0, -1, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(7)), W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(2)), -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
